// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - shared widths, IMEM depth and FSM state encoding for the program loader
package imem_program_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int IMEM_DEPTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_HI,
    S_RX_LO,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - byte handshake and high/low word assembly for the program loader
module imem_loader_byte_packer
  import imem_program_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept_i,
  input  logic              hi_sel_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              xfer_o,
  output logic [WORD_W-1:0] word_o
);

  logic [BYTE_W-1:0] hi_q, hi_d;

  assign byte_ready_o = accept_i;
  assign xfer_o       = byte_valid_i & accept_i;

  // The low byte is consumed straight off the bus on the edge it transfers.
  assign word_o = {hi_q, byte_i};

  always_comb begin
    hi_d = hi_q;
    if (xfer_o && hi_sel_i) begin
      hi_d = byte_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - streams bytes into 16-bit IMEM writes; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int WORD_COUNT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              write_enable_o,
  output logic [ADDR_W-1:0] write_select_o,
  output logic [WORD_W-1:0] imem_input_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              accept;
  logic              xfer;
  logic [WORD_W-1:0] word;
  logic              start_ok;

  assign accept   = (state_q == S_RX_HI) || (state_q == S_RX_LO) || (state_q == S_CHECK);
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  imem_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .accept_i     (accept),
    .hi_sel_i     (state_q == S_RX_HI),
    .byte_i       (byte_in_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .xfer_o       (xfer),
    .word_o       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_LAST = S_CHECK;

  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;

  always_comb begin
    csum_d = csum_q;
    err_d  = err_q;
    if (start_ok) begin
      csum_d = '0;
      err_d  = 1'b0;
    end else if (xfer && (state_q == S_CHECK)) begin
      err_d = (byte_in_i != csum_q);
    end else if (xfer) begin
      csum_d = csum_q + byte_in_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign error_o = err_q;
`else
  localparam state_e AFTER_LAST = S_DONE;

  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_RX_HI;
          addr_d  = '0;
        end
      end
      S_RX_HI: begin
        if (xfer) state_d = S_RX_LO;
      end
      S_RX_LO: begin
        // Capture the write beat here so the strobe lands one edge after the low byte.
        if (xfer) begin
          state_d = S_WRITE;
          sel_d   = addr_q;
          data_d  = word;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = AFTER_LAST;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_RX_HI;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign write_enable_o = (state_q == S_WRITE);
  assign write_select_o = sel_q;
  assign imem_input_o   = data_q;
  assign busy_o         = (state_q == S_RX_HI) || (state_q == S_RX_LO) ||
                          (state_q == S_WRITE) || (state_q == S_CHECK);
  assign done_o         = (state_q == S_DONE);

endmodule

// File: doc/imem_program_loader.md
IMEM_PROGRAM_LOADER -- requirements
Module: imem_program_loader

Interface
REQ-001 Parameter WORD_COUNT, default 16, number of 16-bit words loaded per session; legal range 1..16.
REQ-002 CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-high.
REQ-004 START  input  1  level sampled each cycle; begins a load session when in IDLE or DONE.
REQ-005 BYTE_IN  input  8  stream data byte; high byte of each word first.
REQ-006 BYTE_VALID  input  1  BYTE_IN valid.
REQ-007 BYTE_READY  output  1  loader can accept a byte.
REQ-008 WRITE_ENABLE  output  1  one-cycle IMEM write strobe.
REQ-009 WRITE_SELECT  output  4  IMEM word address for the write.
REQ-010 IMEM_INPUT  output  16  assembled word for the write.
REQ-011 BUSY  output  1  session in progress.
REQ-012 DONE  output  1  session complete; held until next START or RESET.
REQ-013 ERROR  output  1  checksum mismatch on the last session.

Function
REQ-014 A byte transfer SHALL occur only on a rising edge with BYTE_VALID=1 and BYTE_READY=1.
REQ-015 FSM states SHALL be IDLE, RX_HI, RX_LO, WRITE, CHECK, DONE.
REQ-016 IDLE/DONE + START=1: go to RX_HI, address counter := 0, checksum := 0, DONE := 0, ERROR := 0.
REQ-017 RX_HI: a transfer latches BYTE_IN into word[15:8] and moves to RX_LO. RX_LO: a transfer latches word[7:0] and moves to WRITE.
REQ-018 BYTE_READY SHALL be 1 exactly in RX_HI, RX_LO and CHECK, and 0 in all other states.
REQ-019 WRITE lasts exactly one cycle: WRITE_ENABLE=1, WRITE_SELECT=address, IMEM_INPUT=word. Write strobe latency is one cycle after the low-byte transfer.
REQ-020 After WRITE, with address = WORD_COUNT-1, next state is CHECK (REQ-030) or DONE. Otherwise address increments by 1 and next state is RX_HI.
REQ-021 The address SHALL never exceed WORD_COUNT-1; no wrap-around write is permitted.
REQ-022 START while BUSY=1 SHALL be ignored.
REQ-023 BYTE_VALID while BYTE_READY=0 SHALL be ignored with no state change; the stalled stream holds.
REQ-024 BUSY SHALL be 1 in RX_HI, RX_LO, WRITE and CHECK.
REQ-025 DONE SHALL be 1 in the DONE state only.
REQ-026 WRITE_SELECT and IMEM_INPUT SHALL hold their last values when WRITE_ENABLE=0.
REQ-027 The checksum SHALL be the 8-bit modulo-256 sum of all 2*WORD_COUNT data bytes.

Reset
REQ-028 RESET=1 SHALL immediately force: state IDLE, WRITE_ENABLE=0, BYTE_READY=0, BUSY=0, DONE=0, ERROR=0, WRITE_SELECT=0, IMEM_INPUT=0, address=0, checksum=0.
REQ-029 RESET mid-session SHALL abort the session. A partial word SHALL never be written, and previously written IMEM words are left as written.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN, when defined:
- after the last WRITE, enter CHECK and accept one extra byte;
- ERROR := (byte != checksum);
- then go to DONE.
REQ-031 When IMEM_LOADER_CHECKSUM_EN is undefined:
- the CHECK state and checksum logic are absent;
- ERROR is tied to 0;
- the last WRITE goes directly to DONE.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the byte/word/address width constants, and the IMEM depth constant (16).
REQ-033 One sub-module SHALL be used: imem_loader_byte_packer (handles the byte handshake and high/low assembly). The FSM, counter and checksum stay in the top module.

Verification
REQ-034 RESET, then START pulse, then 32 back-to-back bytes 0x00..0x1F with WORD_COUNT=16 -> 16 strobes; word n = {2n, 2n+1}, e.g. addr 0 = 0x0001, addr 15 = 0x1E1F; DONE=1 after the last write.
REQ-035 BYTE_VALID toggled 1/0 every cycle, bytes 0xAB,0xCD -> a single strobe with WRITE_SELECT=0, IMEM_INPUT=0xABCD, one cycle after the 0xCD transfer.
REQ-036 RESET asserted after byte 5 of a session -> no further strobes, all outputs at reset values. A new session then writes address 0 first.
REQ-037 START held high throughout a session -> no restart until DONE. START in DONE restarts at address 0 with DONE cleared.
REQ-038 IMEM_LOADER_CHECKSUM_EN defined, bytes 0x00..0x1F then 0xF0 -> ERROR=0. The same stream then 0xF1 -> ERROR=1, DONE=1.
REQ-039 WORD_COUNT=1, bytes 0x12,0x34 -> exactly one strobe at address 0, value 0x1234; BUSY falls the following cycle (checksum macro undefined).
